// File: rtl/o_buf_controller.sv
// Linebuffer readout: fetches 32-bit words, unpacks them to 8-bit pixels
// and drives a raster video stream with line/frame interrupts.
module o_buf_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              buf_ready,
    input  logic              underrun_clr,
    input  logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    output logic              vsync,
    output logic              hsync,
    output logic              vde,
    output logic [7:0]        o_data,
    output logic              line_done,
    output logic              frame_done,
    output logic              underrun
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          run;
    logic          h_act, v_act, h_last, v_last, wrap;
    logic          line_start, line_ok, line_ok_c, slot;
    logic          vde_r, hs_r, vs_r, ld_r, fd_r;

    assign run        = (state_q == RUN);
    assign h_act      = h_cnt < HW'(H_ACTIVE);
    assign v_act      = v_cnt < VW'(V_ACTIVE);
    assign h_last     = h_cnt == HW'(H_TOTAL - 1);
    assign v_last     = v_cnt == VW'(V_TOTAL - 1);
    assign wrap       = run && h_last && v_last;
    assign line_start = run && (h_cnt == '0);
    assign line_ok_c  = line_start ? buf_ready : line_ok;
    assign slot       = run && h_act && v_act && (h_cnt[1:0] == 2'b00);
    assign rd_en      = slot && line_ok_c;

    assign vde_r = run && h_act && v_act;
    assign hs_r  = run && (h_cnt >= HW'(H_ACTIVE + H_FP))
                       && (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_r  = run && (v_cnt >= VW'(V_ACTIVE + V_FP))
                       && (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));
    assign ld_r  = vde_r && (h_cnt == HW'(H_ACTIVE - 1));
    assign fd_r  = ld_r && (v_cnt == VW'(V_ACTIVE - 1));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // en only matters when idle or at the frame wrap
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (wrap && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Skipped slots still advance addr so later lines stay aligned
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)             addr <= '0;
        else if (!run || wrap)  addr <= '0;
        else if (slot)          addr <= addr + ADDR_W'(1);
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            line_ok  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (line_start) line_ok <= buf_ready;
            if (line_start && v_act && !buf_ready) underrun <= 1'b1;
            else if (underrun_clr)                 underrun <= 1'b0;
        end
    end

    logic       vde1, hs1, vs1, ld1, fd1, ok1, rd_q;
    logic [1:0] idx1;
    logic [31:0] word_q, src;
    logic [7:0]  pix;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vde1 <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            ld1  <= 1'b0;
            fd1  <= 1'b0;
            ok1  <= 1'b0;
            rd_q <= 1'b0;
            idx1 <= 2'b00;
        end else begin
            vde1 <= vde_r;
            hs1  <= hs_r;
            vs1  <= vs_r;
            ld1  <= ld_r;
            fd1  <= fd_r;
            ok1  <= line_ok_c;
            rd_q <= rd_en;
            idx1 <= h_cnt[1:0];
        end
    end

    // Byte 0 comes straight off rd_data; the rest from the latched word
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)    word_q <= '0;
        else if (rd_q) word_q <= rd_data;
    end

    assign src = (idx1 == 2'b00) ? rd_data : word_q;
    assign pix = src[{idx1, 3'b000} +: 8];

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync      <= 1'b0;
            hsync      <= 1'b0;
            vde        <= 1'b0;
            o_data     <= 8'h00;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vsync      <= vs1;
            hsync      <= hs1;
            vde        <= vde1;
            o_data     <= (vde1 && ok1) ? pix : 8'h00;
            line_done  <= ld1;
            frame_done <= fd1;
        end
    end
endmodule

// File: tb/tb_o_buf_controller.sv
// Scoreboard bench for o_buf_controller using a reduced raster
// (14 x 7 total, 8 x 4 active) and a synchronous linebuffer model.
module tb_o_buf_controller;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int AW = 17;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          buf_ready = 1'b1;
    logic          underrun_clr = 1'b0;
    logic [31:0]   rd_data = '0;
    logic [AW-1:0] addr;
    logic          rd_en, vsync, hsync, vde, line_done, frame_done, underrun;
    logic [7:0]    o_data;

    o_buf_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .ADDR_W(AW)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .en(en), .buf_ready(buf_ready),
        .underrun_clr(underrun_clr), .rd_data(rd_data), .addr(addr),
        .rd_en(rd_en), .vsync(vsync), .hsync(hsync), .vde(vde),
        .o_data(o_data), .line_done(line_done), .frame_done(frame_done),
        .underrun(underrun)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk)
        if (rd_en) rd_data <= {4{addr[7:0]}} + 32'h03020100;

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       de;
        logic [7:0] d;
        logic       ld;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    bit m_run, m_ok, m_und;
    int mh, mv;

    function automatic exp_t model_out(input bit ok_now);
        exp_t e;
        bit act;
        int w;
        e = '0;
        if (m_run) begin
            act  = (mh < HA) && (mv < VA);
            e.de = act;
            e.hs = (mh >= HA + HF) && (mh < HA + HF + HS);
            e.vs = (mv >= VA + VF) && (mv < VA + VF + VS);
            if (act && ok_now) begin
                w   = mv * (HA / 4) + mh / 4;
                e.d = 8'(w + mh % 4);
            end
            e.ld = act && (mh == HA - 1);
            e.fd = e.ld && (mv == VA - 1);
        end
        return e;
    endfunction

    task automatic reset_model();
        m_run = 0; m_ok = 0; m_und = 0; mh = 0; mv = 0;
        q.delete();
        q.push_back('0);
    endtask

    // One pclk of stimulus, model advance and scoreboard comparison
    task automatic step();
        bit ok_now, exp_rd, set;
        exp_t e, a;
        int ea;
        #1;
        ok_now = (mh == 0) ? buf_ready : m_ok;
        exp_rd = m_run && mh < HA && mv < VA && mh % 4 == 0 && ok_now;
        checks++;
        if (rd_en !== exp_rd) begin
            failures++;
            $display("FAIL rd_en h=%0d v=%0d got=%b exp=%b", mh, mv, rd_en, exp_rd);
        end
        if (exp_rd) begin
            ea = mv * (HA / 4) + mh / 4;
            checks++;
            if (addr !== AW'(ea)) begin
                failures++;
                $display("FAIL addr h=%0d v=%0d got=%0d exp=%0d", mh, mv, addr, ea);
            end
        end
        q.push_back(model_out(ok_now));
        set = m_run && mh == 0 && mv < VA && !buf_ready;
        if (set) m_und = 1;
        else if (underrun_clr) m_und = 0;
        if (!m_run) begin
            if (en) m_run = 1;
        end else begin
            if (mh == 0) m_ok = buf_ready;
            if (mh == HT - 1) begin
                mh = 0;
                if (mv == VT - 1) begin
                    mv = 0;
                    if (!en) m_run = 0;
                end else mv++;
            end else mh++;
        end
        @(posedge pclk);
        #1;
        e = q.pop_front();
        a = {vsync, hsync, vde, o_data, line_done, frame_done};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL stream got vs/hs/de/d/ld/fd=%b/%b/%b/%h/%b/%b exp=%b/%b/%b/%h/%b/%b",
                     a.vs, a.hs, a.de, a.d, a.ld, a.fd, e.vs, e.hs, e.de, e.d, e.ld, e.fd);
        end
        checks++;
        if (underrun !== m_und) begin
            failures++;
            $display("FAIL underrun_track got=%b exp=%b", underrun, m_und);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; en = 0; buf_ready = 1; underrun_clr = 0;
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if ({vsync, hsync, vde, o_data, line_done, frame_done, rd_en, underrun} !== '0
            || addr !== '0) begin
            failures++;
            $display("FAIL reset_outputs got vde=%b d=%h rd=%b addr=%0d und=%b exp=all0",
                     vde, o_data, rd_en, addr, underrun);
        end
        rst_n = 1;
        reset_model();
    endtask

    task automatic test_basic_stream();
        logic [7:0] exp_px[8] = '{8'h00, 8'h01, 8'h02, 8'h03,
                                  8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] got[8];
        int n = 0, first_de = -1, first_hs = -1, k = 0;
        en = 1;
        while (k < 100 && (n < 8 || first_hs < 0)) begin
            step();
            k++;
            if (vde && n < 8) begin
                if (first_de < 0) first_de = k;
                got[n] = o_data;
                n++;
            end
            if (hsync && first_hs < 0) first_hs = k;
        end
        checks++;
        if (first_de != 3) begin
            failures++;
            $display("FAIL first_vde_latency got=%0d exp=3", first_de);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== exp_px[i]) begin
                failures++;
                $display("FAIL line0_pixel%0d got=%h exp=%h", i, got[i], exp_px[i]);
            end
        end
        checks++;
        if (first_hs - first_de != HA + HF) begin
            failures++;
            $display("FAIL hsync_offset got=%0d exp=%0d", first_hs - first_de, HA + HF);
        end
    endtask

    task automatic test_frame_wrap();
        int vs_n = 0, fd_n = 0, ld_n = 0, bad = 0, runlen = 0, maxrun = 0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step();
            if (vsync) begin
                vs_n++;
                runlen++;
                if (runlen > maxrun) maxrun = runlen;
            end else runlen = 0;
            if (line_done) ld_n++;
            if (frame_done) begin
                fd_n++;
                if (!line_done) bad++;
            end
        end
        checks++;
        if (maxrun != HT || vs_n != 2 * HT) begin
            failures++;
            $display("FAIL vsync_width got=%0d total=%0d exp=%0d", maxrun, vs_n, HT);
        end
        checks++;
        if (fd_n != 2 || bad != 0) begin
            failures++;
            $display("FAIL frame_done_count got=%0d misaligned=%0d exp=2", fd_n, bad);
        end
        checks++;
        if (ld_n != 2 * VA) begin
            failures++;
            $display("FAIL line_done_count got=%0d exp=%0d", ld_n, 2 * VA);
        end
    endtask

    task automatic test_underrun();
        int k = 0;
        while (k < 200 && !(m_run && mh == 0 && mv == 2)) begin
            step();
            k++;
        end
        checks++;
        if (k >= 200) begin
            failures++;
            $display("FAIL underrun_align timeout got=%0d exp<200", k);
        end
        buf_ready = 0;
        step();
        buf_ready = 1;
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_set got=%b exp=1", underrun);
        end
        while (k < 400 && !(mh == 0 && mv == 5)) begin
            step();
            k++;
        end
        underrun_clr = 1;
        step();
        underrun_clr = 0;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear got=%b exp=0", underrun);
        end
    endtask

    task automatic test_enable_stop();
        int k = 0, rd_n = 0, de_n = 0;
        while (k < 200 && !(m_run && mh == 0 && mv == 0)) begin
            step();
            k++;
        end
        repeat (20) step();
        en = 0;
        k = 0;
        while (k < 200 && m_run) begin
            step();
            k++;
        end
        checks++;
        if (k >= 200) begin
            failures++;
            $display("FAIL stop_timeout got=%0d exp<200", k);
        end
        repeat (4) step();
        for (int i = 0; i < 50; i++) begin
            step();
            if (rd_en) rd_n++;
            if (vde || vsync || hsync) de_n++;
        end
        checks++;
        if (rd_n != 0 || de_n != 0) begin
            failures++;
            $display("FAIL stopped_activity got rd=%0d sync/de=%0d exp=0", rd_n, de_n);
        end
        en = 1;
        repeat (30) step();
    endtask

    task automatic test_async_reset();
        int k = 0, first = -1;
        while (k < 200 && !(m_run && mh == 7 && mv == 1)) begin
            step();
            k++;
        end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({vsync, hsync, vde, o_data, line_done, frame_done, rd_en, underrun} !== '0
            || addr !== '0) begin
            failures++;
            $display("FAIL async_reset got vde=%b d=%h rd=%b addr=%0d exp=all0",
                     vde, o_data, rd_en, addr);
        end
        reset_model();
        rst_n = 1;
        en = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (vde && first < 0) first = int'(o_data);
        end
        checks++;
        if (first != 0) begin
            failures++;
            $display("FAIL restart_pixel0 got=%0d exp=0", first);
        end
    endtask

    task automatic test_set_clear();
        int k = 0;
        while (k < 200 && !(m_run && mh == 0 && mv < VA)) begin
            step();
            k++;
        end
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL pre_setclear got=%b exp=0", underrun);
        end
        buf_ready = 0;
        underrun_clr = 1;
        step();
        buf_ready = 1;
        underrun_clr = 0;
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL set_wins got=%b exp=1", underrun);
        end
        repeat (2 * HT) step();
    endtask

    initial begin
        reset_model();
        test_reset();
        test_basic_stream();
        test_frame_wrap();
        test_underrun();
        test_enable_stop();
        test_async_reset();
        test_set_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
